multi_digit_updown_counter: RTL and testbench

- Parametrised successor to the single-digit up/down counter.
- N-digit counter in a configurable base (decimal or hex) with wrap or saturate mode, synchronous load, and hold-to-repeat on the up/down keys.
- Per-digit seven-segment patterns use the team's hex-to-seven-segment decoder.
- Sits between the debounced key outputs and the board's HEX displays.

---
 rtl/multi_digit_updown_counter.sv | 222 ++++++++++++++++++++++
 tb/tb_multi_digit_updown_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_updown_counter.sv
// ---------------------------------------------------------------------------
// multi_digit_updown_counter
//
// N-digit up/down counter in a configurable radix with wrap or saturate
// behaviour at the limits, synchronous load, and hold-to-repeat on the
// up/down keys. Every digit drives its own seven-segment pattern.
//
// Parameters:
//   DIGITS        number of digits (1..8)
//   BASE          radix per digit (2..16)
//   SATURATE      0 = wrap at limits, 1 = clamp at limits
//   REPEAT_DELAY  cycles from press to first auto-repeat step (0 = off)
//   REPEAT_PERIOD cycles between later auto-repeat steps (>= 1)
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   up_lvl    debounced level of the up key (1 = pressed)
//   down_lvl  debounced level of the down key
//   load      synchronous load strobe
//   load_val  packed digit values to load, digit 0 in [3:0]
//   digits    current count, packed, digit 0 least significant
//   segm      seven-segment patterns, digit i in [7i+6:7i], active-low,
//             bit 0 = segment a ... bit 6 = segment g
//   ovf       one-cycle pulse on an up step at maximum
//   unf       one-cycle pulse on a down step at zero
// ---------------------------------------------------------------------------
module multi_digit_updown_counter #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned BASE          = 10,
  parameter int unsigned SATURATE      = 0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_lvl,
  input  logic                  down_lvl,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic [7*DIGITS-1:0]   segm,
  output logic                  ovf,
  output logic                  unf
);

  localparam logic [3:0]  MAXD   = 4'(BASE - 1);
  localparam int unsigned TMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW     = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int unsigned DLY_M1 = (REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0;
  localparam int unsigned PER_M1 = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;

  // Index 0 = up key, index 1 = down key.
  logic [1:0]           w_lvl;
  logic [1:0]           r_prev;
  logic [1:0]           w_press;
  logic [1:0]           w_rep_hit;
  logic [1:0]           w_step;
  logic [1:0]           r_rep;    // 0: waiting for first repeat, 1: in periodic phase
  logic [TW-1:0]        r_tmr [2];

  logic [4*DIGITS-1:0]  r_digits;
  logic                 r_ovf;
  logic                 r_unf;
  logic [4*DIGITS-1:0]  w_inc;
  logic [4*DIGITS-1:0]  w_dec;
  logic [4*DIGITS-1:0]  w_clamped;
  logic                 w_all_max;
  logic                 w_all_zero;

  assign w_lvl = {down_lvl, up_lvl};

  // Press and repeat-step detection. The repeat target switches from the
  // initial delay to the period once the first repeat has fired.
  always_comb begin
    w_press   = '0;
    w_rep_hit = '0;
    w_step    = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      w_press[k]   = w_lvl[k] & ~r_prev[k];
      w_rep_hit[k] = (REPEAT_DELAY != 0) && w_lvl[k] && !w_press[k] &&
                     (r_tmr[k] == (r_rep[k] ? TW'(PER_M1) : TW'(DLY_M1)));
      w_step[k]    = w_press[k] | w_rep_hit[k];
    end
  end

  // Timers run independently of load; only reset or a released key clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_rep  <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        r_tmr[k] <= '0;
      end
    end else begin
      r_prev <= w_lvl;
      for (int unsigned k = 0; k < 2; k++) begin
        if (!w_lvl[k] || w_press[k]) begin
          r_tmr[k] <= '0;
          r_rep[k] <= 1'b0;
        end else if (w_rep_hit[k]) begin
          r_tmr[k] <= '0;
          r_rep[k] <= 1'b1;
        end else if (REPEAT_DELAY != 0) begin
          r_tmr[k] <= r_tmr[k] + 1'b1;
        end
      end
    end
  end

  // Per-digit ripple increment/decrement and load clamping.
  always_comb begin
    logic carry;
    logic borrow;
    logic [3:0] d;
    w_inc      = '0;
    w_dec      = '0;
    w_clamped  = '0;
    carry      = 1'b1;
    borrow     = 1'b1;
    d          = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = r_digits[4*i +: 4];
      if (carry) begin
        if (d == MAXD) begin
          w_inc[4*i +: 4] = '0;
        end else begin
          w_inc[4*i +: 4] = d + 4'd1;
          carry           = 1'b0;
        end
      end else begin
        w_inc[4*i +: 4] = d;
      end
      if (borrow) begin
        if (d == '0) begin
          w_dec[4*i +: 4] = MAXD;
        end else begin
          w_dec[4*i +: 4] = d - 4'd1;
          borrow          = 1'b0;
        end
      end else begin
        w_dec[4*i +: 4] = d;
      end
      // 5-bit compare keeps the check meaningful when BASE is 16.
      if ({1'b0, load_val[4*i +: 4]} > {1'b0, MAXD}) begin
        w_clamped[4*i +: 4] = MAXD;
      end else begin
        w_clamped[4*i +: 4] = load_val[4*i +: 4];
      end
    end
    w_all_max  = carry;
    w_all_zero = borrow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (load) begin
        r_digits <= w_clamped;
      end else if (w_step[0]) begin
        if (w_all_max) begin
          r_ovf <= 1'b1;
          if (SATURATE == 0) begin
            r_digits <= w_inc;
          end
        end else begin
          r_digits <= w_inc;
        end
      end else if (w_step[1]) begin
        if (w_all_zero) begin
          r_unf <= 1'b1;
          if (SATURATE == 0) begin
            r_digits <= w_dec;
          end
        end else begin
          r_digits <= w_dec;
        end
      end
    end
  end

  // Active-low hex-to-seven-segment decode, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] f_hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    segm = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      segm[7*i +: 7] = f_hex7seg(r_digits[4*i +: 4]);
    end
  end

  assign digits = r_digits;
  assign ovf    = r_ovf;
  assign unf    = r_unf;

endmodule

// File: tb/tb_multi_digit_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_multi_digit_updown_counter
//
// Directed bench for multi_digit_updown_counter. Three instances share the
// same stimulus: decimal wrap, decimal saturate and hex wrap, all with two
// digits, REPEAT_DELAY=4 and REPEAT_PERIOD=2.
// ---------------------------------------------------------------------------
module tb_multi_digit_updown_counter;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_9 = 7'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_lvl;
  logic        down_lvl;
  logic        load;
  logic [7:0]  load_val;

  logic [7:0]  digits_w, digits_s, digits_h;
  logic [13:0] segm_w, segm_s, segm_h;
  logic        ovf_w, ovf_s, ovf_h;
  logic        unf_w, unf_s, unf_h;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multi_digit_updown_counter #(
    .DIGITS(2), .BASE(10), .SATURATE(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut_wrap (
    .clk(clk), .rst(rst), .up_lvl(up_lvl), .down_lvl(down_lvl),
    .load(load), .load_val(load_val),
    .digits(digits_w), .segm(segm_w), .ovf(ovf_w), .unf(unf_w)
  );

  multi_digit_updown_counter #(
    .DIGITS(2), .BASE(10), .SATURATE(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .up_lvl(up_lvl), .down_lvl(down_lvl),
    .load(load), .load_val(load_val),
    .digits(digits_s), .segm(segm_s), .ovf(ovf_s), .unf(unf_s)
  );

  multi_digit_updown_counter #(
    .DIGITS(2), .BASE(16), .SATURATE(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut_hex (
    .clk(clk), .rst(rst), .up_lvl(up_lvl), .down_lvl(down_lvl),
    .load(load), .load_val(load_val),
    .digits(digits_h), .segm(segm_h), .ovf(ovf_h), .unf(unf_h)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] e;
    rst      = 1'b1;
    up_lvl   = 1'b0;
    down_lvl = 1'b0;
    load     = 1'b0;
    load_val = '0;
    tick();
    tick();

    // Reset state
    chk("rst_digits_w", digits_w, 8'h00);
    chk("rst_digits_h", digits_h, 8'h00);
    chk("rst_ovf_w", ovf_w, 0);
    chk("rst_unf_w", unf_w, 0);
    chk("rst_segm_w", segm_w, {SEG_0, SEG_0});

    // Single-cycle up pulse
    rst = 1'b0;
    tick();
    up_lvl = 1'b1;
    tick();
    up_lvl = 1'b0;
    chk("pulse_digits_w", digits_w, 8'h01);
    chk("pulse_ovf_w", ovf_w, 0);
    chk("pulse_segm_w", segm_w, {SEG_0, SEG_1});
    tick();

    // Load 0x98, then three presses
    load = 1'b1; load_val = 8'h98;
    tick();
    load = 1'b0;
    chk("load98_w", digits_w, 8'h98);
    chk("load98_ovf_w", ovf_w, 0);
    up_lvl = 1'b1; tick(); up_lvl = 1'b0;
    chk("p1_w", digits_w, 8'h99);
    chk("p1_s", digits_s, 8'h99);
    chk("p1_ovf_s", ovf_s, 0);
    tick();
    up_lvl = 1'b1; tick(); up_lvl = 1'b0;
    chk("p2_w", digits_w, 8'h00);
    chk("p2_ovf_w", ovf_w, 1);
    chk("p2_s", digits_s, 8'h99);
    chk("p2_ovf_s", ovf_s, 1);
    chk("p2_h", digits_h, 8'h9A);
    chk("p2_ovf_h", ovf_h, 0);
    tick();
    chk("p2_ovf_clr_w", ovf_w, 0);
    chk("p2_ovf_clr_s", ovf_s, 0);
    up_lvl = 1'b1; tick(); up_lvl = 1'b0;
    chk("p3_w", digits_w, 8'h01);
    chk("p3_ovf_w", ovf_w, 0);
    chk("p3_s", digits_s, 8'h99);
    chk("p3_ovf_s", ovf_s, 1);
    chk("p3_h", digits_h, 8'h9B);
    tick();

    // Down press from zero
    rst = 1'b1; tick(); rst = 1'b0;
    down_lvl = 1'b1; tick(); down_lvl = 1'b0;
    chk("dn_w", digits_w, 8'h99);
    chk("dn_unf_w", unf_w, 1);
    chk("dn_h", digits_h, 8'hFF);
    chk("dn_unf_h", unf_h, 1);
    chk("dn_s", digits_s, 8'h00);
    chk("dn_unf_s", unf_s, 1);
    tick();
    chk("dn_unf_clr_w", unf_w, 0);

    // Hold up for 10 cycles: steps at offsets 0, 4, 6, 8
    rst = 1'b1; tick(); rst = 1'b0;
    up_lvl = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = (k >= 9) ? 8'h04 : (k >= 7) ? 8'h03 : (k >= 5) ? 8'h02 : 8'h01;
      chk($sformatf("hold_w_%0d", k), digits_w, e);
      chk($sformatf("hold_h_%0d", k), digits_h, e);
    end
    up_lvl = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("release_w_%0d", k), digits_w, 8'h04);
    end

    // Simultaneous up and down rise: up wins
    load = 1'b1; load_val = 8'h05; tick(); load = 1'b0;
    up_lvl = 1'b1; down_lvl = 1'b1; tick(); up_lvl = 1'b0; down_lvl = 1'b0;
    chk("both_w", digits_w, 8'h06);
    tick();
    chk("both_after_w", digits_w, 8'h06);

    // Load coinciding with a press: press discarded, digit clamped
    load = 1'b1; load_val = 8'h3C; up_lvl = 1'b1;
    tick();
    load = 1'b0; up_lvl = 1'b0;
    chk("ldpress_w", digits_w, 8'h39);
    chk("ldpress_s", digits_s, 8'h39);
    chk("ldpress_h", digits_h, 8'h3C);
    chk("ldpress_segm_w", segm_w, {SEG_3, SEG_9});
    tick();
    chk("ldpress_after_w", digits_w, 8'h39);

    // Reset during a hold at 0x42, key still held afterwards
    load = 1'b1; load_val = 8'h42; up_lvl = 1'b1;
    tick();
    load = 1'b0;
    chk("hold42_w", digits_w, 8'h42);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold_w", digits_w, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      e = (k >= 7) ? 8'h03 : (k >= 5) ? 8'h02 : 8'h01;
      chk($sformatf("rehold_w_%0d", k), digits_w, e);
    end
    up_lvl = 1'b0;
    tick();
    tick();
    chk("rehold_release_w", digits_w, 8'h03);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
